// File: rtl/prm_edge_mask_scan_if.sv
// Configuration, control and result bundle for the edge-mask scanner.
// The scanner takes the slave side; the producer/consumer pair takes the master side.
interface prm_edge_mask_scan_if #(
    parameter int N_IN      = 15,
    parameter int N_EDGE    = 256,
    parameter int MAX_CUBES = 4096,
    parameter int EDGE_W    = $clog2(N_EDGE),
    parameter int CA_W      = $clog2(MAX_CUBES)
);
    logic              cfg_we;
    logic [CA_W-1:0]   cfg_addr;
    logic [N_IN-1:0]   cfg_care;
    logic [N_IN-1:0]   cfg_val;
    logic              cfg_last;
    logic              cfg_nul;
    logic              cfg_err;
    logic              start;
    logic [N_IN-1:0]   in_vec;
    logic              busy;
    logic              done;
    logic              err;
    logic              res_valid;
    logic              res_ready;
    logic [EDGE_W-1:0] res_edge;
    logic              res_mask;
    logic [N_EDGE-1:0] mask_bitmap;

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_last, cfg_nul,
        input  start, in_vec, res_ready,
        output cfg_err, busy, done, err, res_valid, res_edge, res_mask, mask_bitmap
    );

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_last, cfg_nul,
        output start, in_vec, res_ready,
        input  cfg_err, busy, done, err, res_valid, res_edge, res_mask, mask_bitmap
    );
endinterface

// File: rtl/prm_edge_mask_scan.sv
// Table-driven PRM edge-mask scanner: walks a sum-of-products cube table once per
// start, streaming one mask per edge and building the full edge bitmap.
module prm_edge_mask_scan #(
    parameter int N_IN      = 15,
    parameter int N_EDGE    = 256,
    parameter int MAX_CUBES = 4096,
    parameter int EDGE_W    = $clog2(N_EDGE),
    parameter int CA_W      = $clog2(MAX_CUBES)
) (
    input  logic                    clk,
    input  logic                    rst,
    prm_edge_mask_scan_if.slave     bus
);
    localparam int ENT_W = 2 * N_IN + 2;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    mem [MAX_CUBES];
    logic [ENT_W-1:0]    rd_q;
    logic                rd_v_q;
    logic                rd_end_q;
    logic                issued_all_q;
    logic                fin_q;
    logic                acc_q, acc_d;
    logic [CA_W-1:0]     addr_q;
    logic [EDGE_W-1:0]   edge_q;
    logic [N_IN-1:0]     vec_q;
    logic                res_valid_q;
    logic [EDGE_W-1:0]   res_edge_q;
    logic                res_mask_q;
    logic [N_EDGE-1:0]   bitmap_q;
    logic                err_q;
    logic                cfg_err_q;
    logic                busy_c, done_c;

    logic [N_IN-1:0]     rd_care, rd_val;
    logic                rd_last, rd_nul;
    logic                scanning, stall, eval_en, cube_hit;
    logic                edge_end, final_edge, exhaust, issue_en, wr_en, start_go;

    assign rd_care  = rd_q[N_IN-1:0];
    assign rd_val   = rd_q[2*N_IN-1:N_IN];
    assign rd_last  = rd_q[2*N_IN];
    assign rd_nul   = rd_q[2*N_IN+1];

    assign scanning   = (state_q == S_SCAN);
    assign stall      = res_valid_q && !bus.res_ready;
    assign eval_en    = scanning && !stall && !fin_q && rd_v_q;
    assign cube_hit   = (((vec_q ^ rd_val) & rd_care) == '0) && !rd_nul;
    assign acc_d      = acc_q | cube_hit;
    assign edge_end   = eval_en && rd_last;
    assign final_edge = edge_end && (edge_q == EDGE_W'(N_EDGE - 1));
    assign exhaust    = eval_en && rd_end_q && !final_edge;
    // Stop fetching the moment the final edge closes so nothing past it is read.
    assign issue_en   = scanning && !stall && !fin_q && !issued_all_q && !final_edge && !exhaust;
    assign wr_en      = bus.cfg_we && !scanning;
    assign start_go   = (state_q == S_IDLE) && bus.start;

    // Table is deliberately outside the reset domain so its contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[bus.cfg_addr] <= {bus.cfg_nul, bus.cfg_last, bus.cfg_val, bus.cfg_care};
        if (issue_en) rd_q <= mem[addr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_SCAN;
            S_SCAN:  if (fin_q && !stall) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q == S_SCAN);
        done_c = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q        <= '0;
            addr_q       <= '0;
            edge_q       <= '0;
            acc_q        <= 1'b0;
            rd_v_q       <= 1'b0;
            rd_end_q     <= 1'b0;
            issued_all_q <= 1'b0;
            fin_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_edge_q   <= '0;
            res_mask_q   <= 1'b0;
            bitmap_q     <= '0;
            err_q        <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && scanning;
            if (start_go) begin
                vec_q        <= bus.in_vec;
                bitmap_q     <= '0;
                err_q        <= 1'b0;
                addr_q       <= '0;
                edge_q       <= '0;
                acc_q        <= 1'b0;
                rd_v_q       <= 1'b0;
                rd_end_q     <= 1'b0;
                issued_all_q <= 1'b0;
                fin_q        <= 1'b0;
                res_valid_q  <= 1'b0;
            end else if (scanning && !stall) begin
                if (issue_en) begin
                    rd_v_q   <= 1'b1;
                    rd_end_q <= (addr_q == CA_W'(MAX_CUBES - 1));
                    addr_q   <= addr_q + 1'b1;
                    if (addr_q == CA_W'(MAX_CUBES - 1)) issued_all_q <= 1'b1;
                end else begin
                    rd_v_q <= 1'b0;
                end
                if (edge_end) begin
                    res_valid_q        <= 1'b1;
                    res_edge_q         <= edge_q;
                    res_mask_q         <= acc_d;
                    bitmap_q[edge_q]   <= acc_d;
                    acc_q              <= 1'b0;
                    edge_q             <= edge_q + 1'b1;
                end else begin
                    res_valid_q <= 1'b0;
                    if (eval_en) acc_q <= acc_d;
                end
                if (final_edge || exhaust) fin_q <= 1'b1;
                if (exhaust) err_q <= 1'b1;
            end
        end
    end

    assign bus.cfg_err     = cfg_err_q;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.err         = err_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_edge    = res_edge_q;
    assign bus.res_mask    = res_mask_q;
    assign bus.mask_bitmap = bitmap_q;
endmodule
